// File: rtl/tage_u_sweep_ctrl.sv
// Periodic aging sweep for TAGE useful counters; shares the tagged-table write port with updates.
// Optional `TAGE_U_SWEEP_FORCE_EN adds force_sweep_i to start a sweep on demand from IDLE.
module tage_u_sweep_ctrl #(
  parameter int unsigned IDX_W       = 9,
  parameter int unsigned NUM_TABLES  = 4,
  parameter int unsigned PERIOD_LOG2 = 18,
  parameter int unsigned STARVE_MAX  = 7
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  br_valid_i,
  input  logic                  upd_req_i,
`ifdef TAGE_U_SWEEP_FORCE_EN
  input  logic                  force_sweep_i,
`endif
  output logic                  upd_gnt_o,
  output logic                  sweep_we_o,
  output logic [IDX_W-1:0]      sweep_idx_o,
  output logic                  sweep_clr_msb_o,
  output logic                  sweep_clr_lsb_o,
  output logic [NUM_TABLES-1:0] sweep_tbl_mask_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned STALL_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWEEP  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t                 state;
  logic [PERIOD_LOG2-1:0] br_cnt;
  logic [IDX_W-1:0]       idx;
  logic [STALL_W-1:0]     stall_cnt;
  logic                   phase;
  logic                   starved;
  logic                   sweep_win;
  logic                   force_sweep;

`ifdef TAGE_U_SWEEP_FORCE_EN
  assign force_sweep = force_sweep_i;
`else
  assign force_sweep = 1'b0;
`endif

  // Update normally owns the port; the sweep steals it only when idle or starved.
  always_comb begin
    starved   = (stall_cnt == STALL_W'(STARVE_MAX));
    sweep_win = (state == SWEEP) && (!upd_req_i || starved);
    upd_gnt_o = (state == SWEEP) ? !sweep_win : upd_req_i;
  end

  assign sweep_we_o       = sweep_win;
  assign sweep_clr_msb_o  = sweep_win & ~phase;
  assign sweep_clr_lsb_o  = sweep_win & phase;
  assign sweep_tbl_mask_o = sweep_win ? '1 : '0;
  assign sweep_idx_o      = idx;
  assign busy_o           = (state != IDLE);
  assign done_o           = (state == FINISH);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      br_cnt    <= '0;
      idx       <= '0;
      stall_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (force_sweep) begin
            br_cnt <= '0;
            state  <= SWEEP;
          end else if (br_valid_i) begin
            br_cnt <= br_cnt + 1'b1;
            if (br_cnt == '1) state <= SWEEP;
          end
        end
        SWEEP: begin
          if (sweep_win) begin
            idx       <= idx + 1'b1;
            stall_cnt <= '0;
            if (idx == '1) state <= FINISH;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        FINISH: begin
          phase <= ~phase;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
